aes256_inv_key_schedule: RTL
============================

AES256_INV_KEY_SCHEDULE -- requirements
Module: aes256_inv_key_schedule

Interface
REQ-001 Parameters: none; round count (14), key width (256) and round-key width (128) are fixed package constants.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new reverse schedule; sampled only in IDLE.
REQ-005 key_in  input  256  cipher key; word 0 in [255:224], word 7 in [31:0]; sampled on accepted start.
REQ-006 key_valid  output  1  round_key_out/round_num_out valid.
REQ-007 key_ready  input  1  consumer accepts the current key when key_valid && key_ready.
REQ-008 round_key_out  output  128  current round key, first word in [127:96].
REQ-009 round_num_out  output  4  round index of round_key_out: 14 down to 0.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse on the cycle after round 0 is accepted.
REQ-012 check_err  output  1  sticky self-check failure flag (see Configuration).

Function
REQ-013 FSM states: IDLE, EXPAND, EMIT; no other state reachable.
REQ-014 IDLE: start=1 loads window W (256 b) = key_in, clears step counter, enters EXPAND; start=0 holds IDLE.
REQ-015 EXPAND: exactly 13 cycles of forward steps; each step shifts W left 128 b and appends 4 new words (standard AES-256 rule: index%8==0 RotWord+SubWord+Rcon, index%8==4 SubWord, else plain XOR).
REQ-016 After the 13th step W holds words 52..59; the FSM enters EMIT with round counter = 14.
REQ-017 Latency: key_valid rises on the 14th rising edge after the edge that accepted start.
REQ-018 EMIT output: round_key_out = W[127:0] for rounds 14..1, W[255:128] for round 0.
REQ-019 Reverse step on each handshake while round counter >= 2: W becomes {recovered words i-4..i-1, W[255:128]}; w[j] = w[j+8] XOR t(w[j+7]), where t is RotWord+SubWord+Rcon_k if (j+8)=8k, SubWord if (j+8)%8==4, else identity.
REQ-020 Rcon_k: k=1..7 -> 01,02,04,08,10,20,40 hex, placed in the MSB byte.
REQ-021 Handshake at round 1 decrements the counter only; W is unchanged.
REQ-022 Handshake at round 0: key_valid drops, done pulses, FSM returns to IDLE.
REQ-023 key_valid held with stable outputs while key_ready=0; no data advance without a handshake.
REQ-024 start while busy is ignored, with no side effects.
REQ-025 start and a round-0 handshake in the same cycle: start is ignored; a new start is needed in IDLE.
REQ-026 One forward or reverse step per cycle; combinational path = one SubWord plus XOR chain.

Reset
REQ-027 reset asserted: state=IDLE, W=0, counters=0, key_valid=0, done=0, busy=0, check_err=0, round_num_out=0, round_key_out=0; takes effect immediately, including mid-EXPAND or mid-EMIT.
REQ-028 After reset deassertion the first start is accepted normally.

Configuration
REQ-029 Macro AES_IKS_SELFCHECK_EN defined: the accepted key_in[255:128] is stored; at the round-0 handshake a mismatch with round_key_out sets check_err until reset or the next accepted start.
REQ-030 Macro undefined: no storage; check_err is tied 0; all other behaviour is identical.

Structure
REQ-031 Shared package holds the FSM state enum, the Rcon table/function, and constants NR=14, KEY_W=256, RK_W=128.
REQ-032 The single sub-module is the existing byte sbox cell (input a, output c), 4 instances, muxed between forward and reverse operands; forward and reverse never overlap.

Verification
REQ-033 Key 000102..1f, key_ready=1: first key 24fc79ccbf0979e9371ac23c6d68de36 round 14 at cycle 14; round 13 4e5a6699a9f24fe07e572baacdf8cdea; round 1 101112..1f; round 0 000102..0f; done pulse; 15 keys total.
REQ-034 Same key with key_ready toggled randomly: identical 15-key sequence; outputs stable while stalled.
REQ-035 Pulse start during EXPAND and during EMIT: ignored; sequence unchanged.
REQ-036 Assert reset at EMIT round 7: all outputs 0 immediately; a following start with key 00..00 yields the correct round 14 key.
REQ-037 With AES_IKS_SELFCHECK_EN defined, force a W bit flip during EMIT: check_err=1 after round 0; a clean run leaves check_err=0.
REQ-038 Back-to-back runs (start on the cycle after done) with two different keys: both sequences are correct with no stale words.

Source files
------------

// File: rtl/aes256_inv_key_schedule_pkg.sv
// ---------------------------------------------------------------------------
// aes256_inv_key_schedule_pkg
// Shared definitions for the AES-256 reverse key schedule:
//   NR, KEY_W, RK_W : round count and key / round-key widths
//   state_t         : FSM state encoding (IDLE, EXPAND, EMIT)
//   rcon()          : round constant byte for k = 1..7
// ---------------------------------------------------------------------------
package aes256_inv_key_schedule_pkg;

  localparam int NR    = 14;
  localparam int KEY_W = 256;
  localparam int RK_W  = 128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_EMIT   = 2'd2
  } state_t;

  // Round constant for AES-256; only k = 1..7 is ever used.
  function automatic logic [7:0] rcon(input logic [3:0] k);
    logic [7:0] r;
    case (k)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes256_inv_key_schedule_if.sv
// ---------------------------------------------------------------------------
// aes256_inv_key_schedule_if
// Request / key-stream bundle of the reverse key schedule.
//   start, key_in            : request a schedule for a 256-bit cipher key
//   key_valid, key_ready     : round-key stream handshake
//   round_key_out            : 128-bit round key, first word in [127:96]
//   round_num_out            : round index of round_key_out (14 down to 0)
//   busy, done, check_err    : status
//   dbg_state                : current FSM state, for observation only
// Modports: master = requester/consumer side, slave = the schedule block.
//
// Handshake: a round key transfers on a rising edge where key_valid and
// key_ready are both high. key_valid never depends on key_ready; once
// raised, key_valid and the key/round outputs hold until that transfer.
// ---------------------------------------------------------------------------
interface aes256_inv_key_schedule_if;
  import aes256_inv_key_schedule_pkg::*;

  logic             start;
  logic [KEY_W-1:0] key_in;
  logic             key_ready;
  logic             key_valid;
  logic [RK_W-1:0]  round_key_out;
  logic [3:0]       round_num_out;
  logic             busy;
  logic             done;
  logic             check_err;
  state_t           dbg_state;

  modport master (
    output start, key_in, key_ready,
    input  key_valid, round_key_out, round_num_out, busy, done, check_err,
           dbg_state
  );

  modport slave (
    input  start, key_in, key_ready,
    output key_valid, round_key_out, round_num_out, busy, done, check_err,
           dbg_state
  );

endinterface

// File: rtl/aes256_inv_key_schedule_sbox.sv
// ---------------------------------------------------------------------------
// aes256_inv_key_schedule_sbox
// Byte-wide AES forward S-box, purely combinational.
//   a : input byte
//   c : substituted byte
// ---------------------------------------------------------------------------
module aes256_inv_key_schedule_sbox (
  input  logic [7:0] a,
  output logic [7:0] c
);

  // Entry for input value v sits at bits [(255-v)*8 +: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign c = SBOX[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes256_inv_key_schedule.sv
// ---------------------------------------------------------------------------
// aes256_inv_key_schedule
// Produces AES-256 round keys in decryption order (round 14 down to 0).
// A 256-bit window W first runs 13 forward expansion steps to reach words
// 52..59, then walks backwards one window step per accepted round key,
// recovering four earlier words from the eight it holds.
//
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : aes256_inv_key_schedule_if.slave (start/key_in request,
//           key_valid/key_ready round-key stream, busy/done/check_err,
//           dbg_state)
//
// Build option AES_IKS_SELFCHECK_EN: keeps the upper half of the accepted
// key and raises a sticky check_err if the emitted round-0 key differs.
// Without it check_err is constant 0.
// ---------------------------------------------------------------------------
module aes256_inv_key_schedule
  import aes256_inv_key_schedule_pkg::*;
(
  input logic                      clk,
  input logic                      reset,
  aes256_inv_key_schedule_if.slave bus
);

  state_t            state, state_next;
  logic [KEY_W-1:0]  win, win_next;
  logic [3:0]        step_cnt, step_next;
  logic [3:0]        rnd, rnd_next;
  logic              valid_q, valid_next;
  logic              done_q, done_next;
  logic [RK_W-1:0]   rk_q, rk_next;
  logic [3:0]        rn_q;

  logic              hs;
  logic [31:0]       sb_in, sb_out, t_word;
  logic              use_rot;
  logic [3:0]        rcon_k;
  logic [31:0]       f0, f1, f2, f3;
  logic [31:0]       r0, r1, r2, r3;
  logic [KEY_W-1:0]  fwd_win, rev_win;

  // Window words: word n of W is win[255-32n -: 32].
  // Forward: W = w[i-8..i-1]; the S-box sees w[i-1].
  // Reverse at round r: W = w[4r-4..4r+3]; the S-box sees w[4r-1], which
  // feeds the only non-trivial transform, that of w[4r-8].
  assign hs      = valid_q & bus.key_ready;
  assign sb_in   = (state == ST_EMIT) ? win[159:128] : win[31:0];
  assign use_rot = (state == ST_EMIT) ? ~rnd[0] : ~step_cnt[0];
  assign rcon_k  = (state == ST_EMIT) ? {1'b0, rnd[3:1]}
                                      : {1'b0, step_cnt[3:1]} + 4'd1;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes256_inv_key_schedule_sbox u_sbox (
      .a (sb_in[8*g +: 8]),
      .c (sb_out[8*g +: 8])
    );
  end

  // Sub-then-rotate equals rotate-then-sub because SubWord is bytewise.
  assign t_word = use_rot ? ({sb_out[23:0], sb_out[31:24]} ^ {rcon(rcon_k), 24'h0})
                          : sb_out;

  assign f0      = win[255:224] ^ t_word;
  assign f1      = win[223:192] ^ f0;
  assign f2      = win[191:160] ^ f1;
  assign f3      = win[159:128] ^ f2;
  assign fwd_win = {win[127:0], f0, f1, f2, f3};

  // Reverse: w[j] = w[j+8] ^ t(w[j+7]); only j = 4r-8 needs the S-box.
  assign r0      = win[127:96] ^ t_word;
  assign r1      = win[95:64]  ^ win[127:96];
  assign r2      = win[63:32]  ^ win[95:64];
  assign r3      = win[31:0]   ^ win[63:32];
  assign rev_win = {r0, r1, r2, r3, win[255:128]};

  always_comb begin
    state_next = state;
    win_next   = win;
    step_next  = step_cnt;
    rnd_next   = rnd;
    valid_next = valid_q;
    done_next  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_next = ST_EXPAND;
          win_next   = bus.key_in;
          step_next  = 4'd0;
          rnd_next   = 4'd0;
        end
      end
      ST_EXPAND: begin
        win_next  = fwd_win;
        step_next = step_cnt + 4'd1;
        if (step_cnt == 4'd12) begin
          state_next = ST_EMIT;
          rnd_next   = 4'(NR);
        end
      end
      ST_EMIT: begin
        // key_valid is registered, so it first rises one cycle into EMIT.
        valid_next = 1'b1;
        if (hs) begin
          if (rnd == 4'd0) begin
            state_next = ST_IDLE;
            valid_next = 1'b0;
            done_next  = 1'b1;
          end else begin
            rnd_next = rnd - 4'd1;
            // Round 1 -> 0 only switches to the upper half of W.
            if (rnd >= 4'd2) win_next = rev_win;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    rk_next = (rnd_next == 4'd0) ? win_next[255:128] : win_next[127:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      win      <= '0;
      step_cnt <= '0;
      rnd      <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      rk_q     <= '0;
      rn_q     <= '0;
    end else begin
      state    <= state_next;
      win      <= win_next;
      step_cnt <= step_next;
      rnd      <= rnd_next;
      valid_q  <= valid_next;
      done_q   <= done_next;
      if (valid_next) begin
        rk_q <= rk_next;
        rn_q <= rnd_next;
      end
    end
  end

`ifdef AES_IKS_SELFCHECK_EN
  logic [RK_W-1:0] key_hi;
  logic            err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_hi <= '0;
      err_q  <= 1'b0;
    end else if (state == ST_IDLE && bus.start) begin
      key_hi <= bus.key_in[255:128];
      err_q  <= 1'b0;
    end else if (state == ST_EMIT && hs && rnd == 4'd0 && rk_q != key_hi) begin
      err_q <= 1'b1;
    end
  end

  assign bus.check_err = err_q;
`else
  assign bus.check_err = 1'b0;
`endif

  assign bus.key_valid     = valid_q;
  assign bus.round_key_out = rk_q;
  assign bus.round_num_out = rn_q;
  assign bus.busy          = (state != ST_IDLE);
  assign bus.done          = done_q;
  assign bus.dbg_state     = state;

endmodule
